ibex_mem_arbiter: RTL and testbench

Shares one OBI-style memory device port between the instruction-fetch and data (LSU) ports of an ibex core. Arbitration and response routing add zero cycles. A small in-order source-ID queue routes each device response back to the host that issued the request. The block sits between the core's instr/data interfaces and a single-ported memory or bus bridge, and stalls hosts when the outstanding-transaction limit is reached.

---
 rtl/ibex_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_ibex_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_arbiter.sv
// Shares one OBI-style device port between the ibex instruction and data hosts,
// routing responses back in order. Define IBEX_MEM_ARB_RR_EN for round-robin conflict arbitration.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        dev_req_o,
    input  logic        dev_gnt_i,
    input  logic        dev_rvalid_i,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wdata_o,
    input  logic [31:0] dev_rdata_i,
    input  logic        dev_err_i,

    output logic        unexp_rsp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    localparam logic SelInstr = 1'b0;
    localparam logic SelData  = 1'b1;

    logic [CntW-1:0]           count_q, count_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic                      lock_q, lock_d;
    logic                      sel_q, sel_d;
    logic                      unexp_q, unexp_d;

    logic sel, sel_req, can_issue, push, pop, head;

`ifdef IBEX_MEM_ARB_RR_EN
    logic rr_q, rr_d;
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : PtrW'(p + 1'b1);
    endfunction

    assign can_issue = (count_q < CntW'(MaxOutstanding));

    // A locked selection keeps the device request fields stable until granted.
    always_comb begin
        sel = SelInstr;
        if (lock_q) begin
            sel = sel_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
            sel = rr_q;
`else
            sel = SelData;
`endif
        end else if (data_req_i) begin
            sel = SelData;
        end
    end

    assign sel_req     = (sel == SelData) ? data_req_i : instr_req_i;
    assign dev_req_o   = can_issue & sel_req;
    assign push        = dev_req_o & dev_gnt_i;
    assign instr_gnt_o = push & (sel == SelInstr);
    assign data_gnt_o  = push & (sel == SelData);

    assign dev_we_o    = (sel == SelData) ? data_we_i    : 1'b0;
    assign dev_be_o    = (sel == SelData) ? data_be_i    : 4'hF;
    assign dev_addr_o  = (sel == SelData) ? data_addr_i  : instr_addr_i;
    assign dev_wdata_o = (sel == SelData) ? data_wdata_i : 32'h0;

    assign pop            = dev_rvalid_i & (count_q != '0);
    assign head           = fifo_q[rd_ptr_q];
    assign instr_rvalid_o = pop & (head == SelInstr);
    assign data_rvalid_o  = pop & (head == SelData);
    assign instr_rdata_o  = dev_rdata_i;
    assign data_rdata_o   = dev_rdata_i;
    assign instr_err_o    = dev_err_i;
    assign data_err_o     = dev_err_i;
    assign unexp_rsp_o    = unexp_q;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lock_d   = dev_req_o & ~dev_gnt_i;
        sel_d    = sel;
        unexp_d  = unexp_q | (dev_rvalid_i & (count_q == '0));
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

`ifdef IBEX_MEM_ARB_RR_EN
    // Preference passes to the host that lost each grant.
    assign rr_d = push ? ~sel : rr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= SelData;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fifo_q   <= '0;
            lock_q   <= 1'b0;
            sel_q    <= SelInstr;
            unexp_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fifo_q   <= fifo_d;
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            unexp_q  <= unexp_d;
        end
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Randomized scoreboard bench for ibex_mem_arbiter: a transaction-level model predicts
// grants and device fields each cycle and queues expected responses for a separate monitor.
module tb_ibex_mem_arbiter;

    localparam int MO     = 2;
    localparam int NCYC   = 3000;
    localparam int RST_AT = 1500;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        dev_req_o, dev_gnt_i, dev_rvalid_i, dev_we_o, dev_err_i, unexp_rsp_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o, dev_wdata_o, dev_rdata_i;

    ibex_mem_arbiter #(.MaxOutstanding(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
        .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_addr_o(dev_addr_o),
        .dev_wdata_o(dev_wdata_o), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
        .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        bit          src;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = -1;
    rsp_t sb[$];

    // Model: sources of accepted, unanswered transactions, in issue order.
    bit   src_q[$];
    int   owner;
    bit   pref;
    bit   m_unexp;

    bit          ip, dp, dwe;
    logic [31:0] ia, da, dw;
    logic [3:0]  dbe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        src_q.delete();
        owner   = -1;
        pref    = 1'b1;
        m_unexp = 1'b0;
        ip      = 1'b0;
        dp      = 1'b0;
    endtask

    task automatic zero_inputs();
        instr_req_i = 0; instr_addr_i = '0;
        data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        dev_gnt_i = 0; dev_rvalid_i = 0; dev_rdata_i = '0; dev_err_i = 0;
    endtask

    // Monitor: whenever a host rvalid is presented it must match the queue head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("instr_rvalid", instr_rvalid_o, !e.src);
                chk("data_rvalid", data_rvalid_o, e.src);
                chk("rsp_rdata", e.src ? data_rdata_o : instr_rdata_o, e.rdata);
                chk("rsp_err", e.src ? data_err_o : instr_err_o, e.err);
            end else begin
                chk("rvalid_idle", {instr_rvalid_o, data_rvalid_o}, 0);
            end
        end
    end

    initial begin
        bit can, exp_req;
        int win;
        zero_inputs();
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_dev_req", dev_req_o, 0);
        chk("rst_instr_gnt", instr_gnt_o, 0);
        chk("rst_data_gnt", data_gnt_o, 0);
        chk("rst_unexp", unexp_rsp_o, 0);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk_i);
            #1;
            cyc    = c;
            rst_ni = (c != RST_AT);
            if (c == RST_AT) begin
                model_reset();
                sb.delete();
                zero_inputs();
            end else begin
                if (!ip && $urandom_range(0, 2) == 0) begin
                    ip = 1'b1;
                    ia = $urandom;
                end
                if (!dp && $urandom_range(0, 2) == 0) begin
                    dp  = 1'b1;
                    da  = $urandom;
                    dw  = $urandom;
                    dbe = 4'($urandom);
                    dwe = 1'($urandom);
                end
                instr_req_i  = ip;
                instr_addr_i = ia;
                data_req_i   = dp;
                data_addr_i  = da;
                data_wdata_i = dw;
                data_be_i    = dbe;
                data_we_i    = dwe;
                dev_gnt_i    = ($urandom_range(0, 9) < 7);
                dev_rvalid_i = (src_q.size() > 0) ? ($urandom_range(0, 9) < 4)
                                                  : ($urandom_range(0, 99) < 4);
                dev_rdata_i  = $urandom;
                dev_err_i    = ($urandom_range(0, 9) == 0);
            end

            @(negedge clk_i);
            can = (src_q.size() < MO);
            if (owner >= 0) win = owner;
`ifdef IBEX_MEM_ARB_RR_EN
            else if (ip && dp) win = pref;
`else
            else if (ip && dp) win = 1;
`endif
            else if (dp) win = 1;
            else if (ip) win = 0;
            else win = -1;
            exp_req = can && (win >= 0) && ((win == 1) ? dp : ip);

            chk("dev_req", dev_req_o, exp_req);
            chk("instr_gnt", instr_gnt_o, exp_req && win == 0 && dev_gnt_i);
            chk("data_gnt", data_gnt_o, exp_req && win == 1 && dev_gnt_i);
            chk("unexp_rsp", unexp_rsp_o, m_unexp);
            if (exp_req) begin
                chk("dev_addr", dev_addr_o, (win == 1) ? da : ia);
                chk("dev_we", dev_we_o, (win == 1) ? dwe : 1'b0);
                chk("dev_be", dev_be_o, (win == 1) ? dbe : 4'hF);
                chk("dev_wdata", dev_wdata_o, (win == 1) ? dw : 32'h0);
            end

            // Responses retire against the queue as it stood before this edge.
            if (dev_rvalid_i) begin
                if (src_q.size() > 0) begin
                    rsp_t e;
                    e.cyc   = c;
                    e.src   = src_q.pop_front();
                    e.rdata = dev_rdata_i;
                    e.err   = dev_err_i;
                    sb.push_back(e);
                end else begin
                    m_unexp = 1'b1;
                end
            end

            if (exp_req && dev_gnt_i) begin
                src_q.push_back(win[0]);
                if (win == 1) dp = 1'b0;
                else ip = 1'b0;
                owner = -1;
                pref  = ~win[0];
            end else if (exp_req) begin
                owner = win;
            end else begin
                owner = -1;
            end
        end

        @(posedge clk_i);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
